// File: rtl/fc8_interrupt_sequencer.sv
// fc8_interrupt_sequencer: arbitrates NMI/IRQ at instruction boundaries, pushes PC and flags,
// fetches the vector and hands PC/SP/I-flag updates back to the FC8 core.
module fc8_interrupt_sequencer #(
   parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
   parameter logic [15:0] IRQ_VECTOR = 16'hFFFE,
   parameter logic [7:0]  STACK_PAGE = 8'h01
) (
   input  logic        clk_cpu,
   input  logic        rst_n,
   input  logic        nmi_req,
   input  logic        irq_req,
   input  logic        irq_mask,
   input  logic        insn_boundary,
   input  logic [15:0] pc_in,
   input  logic [7:0]  flags_in,
   input  logic [7:0]  sp_in,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ready,
   output logic        pc_load,
   output logic [15:0] pc_out,
   output logic        sp_load,
   output logic [7:0]  sp_out,
   output logic        set_irq_mask,
   output logic        nmi_pending
);
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_PUSH_PCH   = 3'd1;
   localparam logic [2:0] S_PUSH_PCL   = 3'd2;
   localparam logic [2:0] S_PUSH_FLAGS = 3'd3;
   localparam logic [2:0] S_VEC_LO     = 3'd4;
   localparam logic [2:0] S_VEC_HI     = 3'd5;
   localparam logic [2:0] S_LOAD       = 3'd6;

   logic [2:0]  state_q, state_d;
   logic        nmi_prev_q, nmi_pend_q, nmi_pend_d, sel_nmi_q, sel_nmi_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  flags_q, flags_d, sp_q, sp_d, lo_q, lo_d, hi_q, hi_d;
   logic        commit, is_push, is_vec, xfer;

   assign is_push = state_q == S_PUSH_PCH || state_q == S_PUSH_PCL || state_q == S_PUSH_FLAGS;
   assign is_vec  = state_q == S_VEC_LO || state_q == S_VEC_HI;
   assign xfer    = bus_req && bus_ready;
   assign commit  = state_q == S_IDLE && insn_boundary && (nmi_pend_q || (irq_req && !irq_mask));

   assign busy         = state_q != S_IDLE;
   assign bus_req      = is_push || is_vec;
   assign bus_we       = is_push;
   assign bus_addr     = is_push ? {STACK_PAGE, sp_q} :
                         is_vec  ? (sel_nmi_q ? NMI_VECTOR : IRQ_VECTOR) + {15'd0, state_q == S_VEC_HI} :
                                   16'h0000;
   assign bus_wdata    = state_q == S_PUSH_PCH   ? pc_q[15:8] :
                         state_q == S_PUSH_PCL   ? pc_q[7:0]  :
                         state_q == S_PUSH_FLAGS ? flags_q    : 8'h00;
   assign pc_load      = state_q == S_LOAD;
   assign sp_load      = state_q == S_LOAD;
   assign set_irq_mask = state_q == S_LOAD;
   assign pc_out       = {hi_q, lo_q};
   assign sp_out       = sp_q;
   assign nmi_pending  = nmi_pend_q;

   // A commit with nmi_pend_q set is always an NMI commit, so a fresh edge still wins over the clear.
   assign nmi_pend_d = (nmi_req && !nmi_prev_q) || (nmi_pend_q && !commit);

   always_comb begin
      state_d   = state_q;
      sel_nmi_d = sel_nmi_q;
      pc_d      = pc_q;
      flags_d   = flags_q;
      sp_d      = sp_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      if (commit) begin
         pc_d      = pc_in;
         flags_d   = flags_in;
         sp_d      = sp_in;
         sel_nmi_d = nmi_pend_q;
         state_d   = S_PUSH_PCH;
      end
      if (xfer) begin
         if (is_push) sp_d = sp_q - 8'd1;
         if (state_q == S_VEC_LO) lo_d = bus_rdata;
         if (state_q == S_VEC_HI) hi_d = bus_rdata;
         state_d = state_q + 3'd1;
      end
      if (state_q == S_LOAD) state_d = S_IDLE;
   end

   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
         sel_nmi_q  <= 1'b0;
         pc_q       <= 16'h0000;
         flags_q    <= 8'h00;
         sp_q       <= 8'h00;
         lo_q       <= 8'h00;
         hi_q       <= 8'h00;
      end else begin
         state_q    <= state_d;
         nmi_prev_q <= nmi_req;
         nmi_pend_q <= nmi_pend_d;
         sel_nmi_q  <= sel_nmi_d;
         pc_q       <= pc_d;
         flags_q    <= flags_d;
         sp_q       <= sp_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
      end
   end
endmodule

// File: tb/tb_fc8_interrupt_sequencer.sv
// tb_fc8_interrupt_sequencer: directed checks of the interrupt entry sequencer against
// hand-computed bus traces, latencies and handoff values.
module tb_fc8_interrupt_sequencer;
   logic        clk_cpu = 1'b0;
   logic        rst_n = 1'b0;
   logic        nmi_req = 1'b0, irq_req = 1'b0, irq_mask = 1'b0, insn_boundary = 1'b0;
   logic [15:0] pc_in = 16'h1234;
   logic [7:0]  flags_in = 8'hA5, sp_in = 8'hFF;
   logic        busy, bus_req, bus_we, bus_ready, pc_load, sp_load, set_irq_mask, nmi_pending;
   logic [15:0] bus_addr, pc_out;
   logic [7:0]  bus_wdata, bus_rdata, sp_out;

   int checks = 0, failures = 0;
   int cyc = 0, waits = 0, wcnt = 0;
   int req_cycles = 0, stab_err = 0, pulse_err = 0;
   logic [24:0] log_q[$];
   logic [15:0] load_pc[$];
   logic [7:0]  load_sp[$];
   int          load_cyc[$], busy_starts[$];
   logic        post_busy[$];
   logic        prev_busy = 1'b0, prev_load = 1'b0, hold_v = 1'b0;
   logic [24:0] hold_bus;

   fc8_interrupt_sequencer dut (
      .clk_cpu(clk_cpu), .rst_n(rst_n), .nmi_req(nmi_req), .irq_req(irq_req),
      .irq_mask(irq_mask), .insn_boundary(insn_boundary), .pc_in(pc_in),
      .flags_in(flags_in), .sp_in(sp_in), .busy(busy), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .pc_load(pc_load),
      .pc_out(pc_out), .sp_load(sp_load), .sp_out(sp_out),
      .set_irq_mask(set_irq_mask), .nmi_pending(nmi_pending)
   );

   always #5 clk_cpu = ~clk_cpu;

   function automatic logic [7:0] rd(input logic [15:0] a);
      return a == 16'hFFFA ? 8'h00 : a == 16'hFFFB ? 8'h80 :
             a == 16'hFFFE ? 8'h34 : a == 16'hFFFF ? 8'h12 : 8'hEE;
   endfunction

   assign bus_rdata = rd(bus_addr);
   assign bus_ready = wcnt == waits;

   always @(posedge clk_cpu) cyc <= cyc + 1;

   always @(posedge clk_cpu or negedge rst_n)
      if (!rst_n) wcnt <= 0;
      else wcnt <= (bus_req && !bus_ready) ? wcnt + 1 : 0;

   // Observes the DUT mid-cycle: transfers, wait-state stability and handoff pulses.
   always @(negedge clk_cpu) begin
      if (!rst_n) begin
         hold_v    <= 1'b0;
         prev_busy <= 1'b0;
         prev_load <= 1'b0;
      end else begin
         if (bus_req) req_cycles <= req_cycles + 1;
         if (bus_req && bus_ready) log_q.push_back({bus_we, bus_addr, bus_we ? bus_wdata : bus_rdata});
         if (hold_v && (!bus_req || {bus_we, bus_addr, bus_wdata} != hold_bus)) stab_err <= stab_err + 1;
         hold_v   <= bus_req && !bus_ready;
         hold_bus <= {bus_we, bus_addr, bus_wdata};
         if (busy && !prev_busy) busy_starts.push_back(cyc);
         if (pc_load !== sp_load || pc_load !== set_irq_mask) pulse_err <= pulse_err + 1;
         if (pc_load) begin
            load_pc.push_back(pc_out);
            load_sp.push_back(sp_out);
            load_cyc.push_back(cyc);
         end
         if (prev_load) post_busy.push_back(busy);
         prev_busy <= busy;
         prev_load <= pc_load;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic clear_logs();
      log_q.delete();
      load_pc.delete();
      load_sp.delete();
      load_cyc.delete();
      busy_starts.delete();
      post_busy.delete();
   endtask

   task automatic wait_loads(input int n, input string tag);
      int k = 0;
      while ((load_pc.size() < n || busy) && k < 300) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, k < 300}, 1);
   endtask

   task automatic run_irq();
      irq_req = 1'b1;
      tick();
      irq_req = 1'b0;
   endtask

   initial begin
      int k;
      insn_boundary = 1'b1;
      repeat (3) tick();
      chk("rst_ctl", {25'd0, busy, bus_req, bus_we, pc_load, sp_load, set_irq_mask, nmi_pending}, 0);
      chk("rst_data", {bus_addr, pc_out}, 0);
      chk("rst_sp", {24'd0, sp_out}, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      clear_logs();
      run_irq();
      wait_loads(1, "irq_done");
      chk("irq_n", log_q.size(), 5);
      chk("irq_w0", log_q[0], {1'b1, 16'h01FF, 8'h12});
      chk("irq_w1", log_q[1], {1'b1, 16'h01FE, 8'h34});
      chk("irq_w2", log_q[2], {1'b1, 16'h01FD, 8'hA5});
      chk("irq_r0", log_q[3], {1'b0, 16'hFFFE, 8'h34});
      chk("irq_r1", log_q[4], {1'b0, 16'hFFFF, 8'h12});
      chk("irq_pc", load_pc[0], 16'h1234);
      chk("irq_sp", load_sp[0], 8'hFC);
      chk("irq_t6", load_cyc[0] - busy_starts[0], 5);
      chk("irq_t7", post_busy[0], 0);

      clear_logs();
      insn_boundary = 1'b0;
      nmi_req = 1'b1;
      irq_req = 1'b1;
      repeat (2) tick();
      chk("pri_pend", {busy, nmi_pending}, 2'b01);
      insn_boundary = 1'b1;
      tick();
      chk("pri_clr", {busy, nmi_pending}, 2'b10);
      k = 0;
      while (busy_starts.size() < 2 && k < 50) begin
         tick();
         k++;
      end
      irq_req = 1'b0;
      nmi_req = 1'b0;
      chk("pri_second", busy_starts.size(), 2);
      wait_loads(2, "pri_done");
      chk("pri_nmi_vec", {log_q[3][23:8], log_q[4][23:8]}, {16'hFFFA, 16'hFFFB});
      chk("pri_nmi_pc", load_pc[0], 16'h8000);
      chk("pri_irq_vec", {log_q[8][23:8], log_q[9][23:8]}, {16'hFFFE, 16'hFFFF});
      chk("pri_irq_pc", load_pc[1], 16'h1234);
      chk("pri_b2b", busy_starts[1] - load_cyc[0], 2);

      clear_logs();
      k = req_cycles;
      irq_mask = 1'b1;
      irq_req = 1'b1;
      repeat (20) tick();
      chk("mask_req", req_cycles - k, 0);
      chk("mask_busy", {31'd0, busy}, 0);
      irq_req = 1'b0;
      irq_mask = 1'b0;

      clear_logs();
      nmi_req = 1'b1;
      repeat (100) tick();
      nmi_req = 1'b0;
      repeat (20) tick();
      chk("nmi_once", load_pc.size(), 1);
      chk("nmi_once_pc", load_pc[0], 16'h8000);
      chk("nmi_once_pend", {31'd0, nmi_pending}, 0);

      clear_logs();
      waits = 3;
      sp_in = 8'h01;
      run_irq();
      wait_loads(1, "wait_done");
      chk("wait_t21", load_cyc[0] - busy_starts[0], 20);
      chk("wrap_a0", log_q[0][23:8], 16'h0101);
      chk("wrap_a1", log_q[1][23:8], 16'h0100);
      chk("wrap_a2", log_q[2][23:8], 16'h01FF);
      chk("wrap_sp", load_sp[0], 8'hFE);
      chk("wait_pc", load_pc[0], 16'h1234);
      sp_in = 8'hFF;

      clear_logs();
      run_irq();
      k = 0;
      while (bus_addr != 16'hFFFE && k < 100) begin
         tick();
         k++;
      end
      chk("rst_reach", bus_addr, 16'hFFFE);
      rst_n = 1'b0;
      #1;
      chk("rst_async", {29'd0, busy, bus_req, pc_load}, 0);
      chk("rst_addr", bus_addr, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_noload", load_pc.size(), 0);
      waits = 0;
      run_irq();
      wait_loads(1, "rst_after");
      chk("rst_after_pc", load_pc[0], 16'h1234);

      clear_logs();
      run_irq();
      nmi_req = 1'b1;
      tick();
      chk("mid_latch", {busy, nmi_pending}, 2'b11);
      nmi_req = 1'b0;
      wait_loads(2, "mid_done");
      chk("mid_first_pc", load_pc[0], 16'h1234);
      chk("mid_b2b", busy_starts[1] - load_cyc[0], 2);
      chk("mid_nmi_pc", load_pc[1], 16'h8000);
      chk("mid_nmi_vec", log_q[8][23:8], 16'hFFFA);

      chk("pulse_align", pulse_err, 0);
      chk("wait_stable", stab_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
